// File: rtl/voice_pkg.sv
// Shared constants for the voice-match datapath: score width, the
// saturated "no match yet" score, and the score_select FSM encoding.
package voice_pkg;

    localparam int unsigned SCORE_W = 8;
    localparam logic [SCORE_W-1:0] SCORE_MAX = 8'hFF;

    // Template-search FSM states.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LAUNCH = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

endpackage

// File: rtl/score_select.sv
// score_select: sequences the DTW scorer over every stored template and
// reports the lowest-scoring one.
//
// Ports:
//   clock, reset_n      single rising-edge clock, async active-low reset
//   go                  one-cycle start pulse, honoured only when idle
//   tmpl_sel            template index driven to the DTW scorer
//   dtw_start           one-cycle start pulse to the DTW scorer
//   dtw_done, dtw_score scorer completion pulse and its distance
//   busy                high from the accepted go until result_valid
//   result_valid        one-cycle pulse, result outputs updated with it
//   best_idx/best_score winning template and its distance
//   reject              best_score above REJECT_THRESH
//
// Build option: define SCORE_REJECT_EN to enable the reject comparator;
// otherwise reject is tied low.
module score_select
    import voice_pkg::*;
#(
    parameter int unsigned NUM_TEMPLATES = 8,
    parameter int unsigned IDX_W = 3,
    parameter logic [SCORE_W-1:0] REJECT_THRESH = 8'd200
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               go,
    output logic [IDX_W-1:0]   tmpl_sel,
    output logic               dtw_start,
    input  logic               dtw_done,
    input  logic [SCORE_W-1:0] dtw_score,
    output logic               busy,
    output logic               result_valid,
    output logic [IDX_W-1:0]   best_idx,
    output logic [SCORE_W-1:0] best_score,
    output logic               reject
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TEMPLATES - 1);

    logic [1:0]         state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [SCORE_W-1:0] min_q, min_d;
    logic [IDX_W-1:0]   min_idx_q, min_idx_d;
    logic               start_q, start_d;
    logic               busy_q, busy_d;
    logic               valid_q, valid_d;
    logic [IDX_W-1:0]   best_idx_q, best_idx_d;
    logic [SCORE_W-1:0] best_score_q, best_score_d;

    // State and all registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            min_q        <= SCORE_MAX;
            min_idx_q    <= '0;
            start_q      <= 1'b0;
            busy_q       <= 1'b0;
            valid_q      <= 1'b0;
            best_idx_q   <= '0;
            best_score_q <= SCORE_MAX;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            min_q        <= min_d;
            min_idx_q    <= min_idx_d;
            start_q      <= start_d;
            busy_q       <= busy_d;
            valid_q      <= valid_d;
            best_idx_q   <= best_idx_d;
            best_score_q <= best_score_d;
        end
    end

    // Next state and next register values. dtw_start and result_valid are
    // computed one state early so the registered pulse lines up with
    // LAUNCH and with the cycle after DONE respectively.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        min_d        = min_q;
        min_idx_d    = min_idx_q;
        start_d      = 1'b0;
        busy_d       = busy_q;
        valid_d      = 1'b0;
        best_idx_d   = best_idx_q;
        best_score_d = best_score_q;

        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    idx_d     = '0;
                    min_d     = SCORE_MAX;
                    min_idx_d = '0;
                    busy_d    = 1'b1;
                    start_d   = 1'b1;
                    state_d   = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (dtw_done) begin
                    // Strict compare: on a tie the earlier template wins.
                    if (dtw_score < min_q) begin
                        min_d     = dtw_score;
                        min_idx_d = idx_q;
                    end
                    if (idx_q < LAST_IDX) begin
                        idx_d   = idx_q + 1'b1;
                        start_d = 1'b1;
                        state_d = ST_LAUNCH;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                best_idx_d   = min_idx_q;
                best_score_d = min_q;
                valid_d      = 1'b1;
                busy_d       = 1'b0;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef SCORE_REJECT_EN
    logic reject_q, reject_d;

    // Reject flag is captured together with best_score.
    always_comb begin
        reject_d = reject_q;
        if (state_q == ST_DONE) begin
            reject_d = (min_q > REJECT_THRESH);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            reject_q <= 1'b0;
        end else begin
            reject_q <= reject_d;
        end
    end

    assign reject = reject_q;
`else
    logic [SCORE_W-1:0] reject_thresh_unused;
    assign reject_thresh_unused = REJECT_THRESH;
    assign reject = 1'b0;
`endif

    assign tmpl_sel     = idx_q;
    assign dtw_start    = start_q;
    assign busy         = busy_q;
    assign result_valid = valid_q;
    assign best_idx     = best_idx_q;
    assign best_score   = best_score_q;

endmodule
